// File: rtl/mem_burst_pkg.sv
// Shared types and default widths for the memory burst controller.
// Imported by the interface, the read-latency pipe and the top.
package mem_burst_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } rd_token_t;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Request/response port between the burst master and the single-port memory.
// master = burst controller side, slave = memory side.
interface mem_burst_ctrl_if
    import mem_burst_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);
    logic          mem_valid_o;
    logic          mem_ready_i;
    logic          mem_wr_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wr_data_o;
    logic [DW-1:0] mem_rd_data_i;

    modport master (
        output mem_valid_o,
        output mem_wr_rd_o,
        output mem_addr_o,
        output mem_wr_data_o,
        input  mem_ready_i,
        input  mem_rd_data_i
    );

    modport slave (
        input  mem_valid_o,
        input  mem_wr_rd_o,
        input  mem_addr_o,
        input  mem_wr_data_o,
        output mem_ready_i,
        output mem_rd_data_i
    );

endinterface

// File: rtl/mem_rd_lat_pipe.sv
// Shift pipe that delays read tokens to line up with memory read data.
// Cleared asynchronously so an aborted burst leaves no pending beats.
module mem_rd_lat_pipe
    import mem_burst_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  rd_token_t tok_i,
    output rd_token_t tok_o
);

    rd_token_t [DEPTH-1:0] pipe_q;
    rd_token_t [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = tok_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tok_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst master: takes one command, then issues one memory beat per
// handshake, streaming write data in and read data out.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int LEN_WIDTH  = LEN_W,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_last,
    output logic                  busy_o,
    output logic                  done_o,
    mem_burst_ctrl_if.master      mem
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  live_q, live_d;

    logic      hs;
    logic      rd_hs;
    rd_token_t tok_in;
    rd_token_t tok_out;

    // Memory request muxing; write path is a pure pass-through.
    always_comb begin
        mem.mem_valid_o   = 1'b0;
        mem.mem_wr_rd_o   = 1'b0;
        mem.mem_wr_data_o = '0;
        wdata_ready       = 1'b0;
        unique case (state_q)
            WRITE: begin
                mem.mem_valid_o   = wdata_valid;
                mem.mem_wr_rd_o   = 1'b1;
                mem.mem_wr_data_o = wdata;
                wdata_ready       = mem.mem_ready_i;
            end
            READ: begin
                mem.mem_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign hs    = mem.mem_valid_o && mem.mem_ready_i;
    assign rd_hs = hs && (state_q == READ);
    assign tok_in = {rd_hs, rd_hs && (cnt_q == '0)};

    mem_rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clk   (clk),
        .rst   (rst),
        .tok_i (tok_in),
        .tok_o (tok_out)
    );

    assign rdata_valid = tok_out.valid;
    assign rdata_last  = tok_out.valid && tok_out.last;
    assign rdata       = tok_out.valid ? mem.mem_rd_data_i : '0;

    // live_q keeps cmd_ready low while reset is asserted.
    assign cmd_ready      = live_q && (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign mem.mem_addr_o = addr_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        live_d  = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = cmd_wr ? WRITE : READ;
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                end
            end
            WRITE, READ: begin
                if (hs) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    cnt_d  = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == '0) begin
                        state_d = (state_q == WRITE) ? IDLE : DRAIN;
                        done_d  = (state_q == WRITE);
                    end
                end
            end
            DRAIN: begin
                if (rdata_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            live_q  <= live_d;
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: directed bursts plus random bursts checked
// against a flat memory image and per-burst beat expectations.
module tb_mem_burst_ctrl;
    import mem_burst_pkg::*;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int LW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wdata_valid = 1'b0;
    logic          wdata_ready;
    logic [DW-1:0] wdata = '0;
    logic          rdata_valid;
    logic [DW-1:0] rdata;
    logic          rdata_last;
    logic          busy_o;
    logic          done_o;

    mem_burst_ctrl_if #(.AW(AW), .DW(DW)) mif ();

    mem_burst_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .RD_LAT     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory with one-cycle read latency, plus handshake log.
    logic [DW-1:0] bfm_mem [DEPTH];
    int cyc = 0;
    int hs_addr[$];
    int hs_wr[$];
    int hs_cyc[$];

    always @(posedge clk) begin
        if (mif.mem_valid_o && mif.mem_ready_i) begin
            hs_addr.push_back(int'(mif.mem_addr_o));
            hs_wr.push_back(int'(mif.mem_wr_rd_o));
            hs_cyc.push_back(cyc);
            if (mif.mem_wr_rd_o)
                bfm_mem[mif.mem_addr_o] <= mif.mem_wr_data_o;
            else
                mif.mem_rd_data_i <= bfm_mem[mif.mem_addr_o];
        end
        cyc <= cyc + 1;
    end

    logic [DW-1:0] rq_data[$];
    bit rq_last[$];
    int rq_cyc[$];
    int done_cnt = 0;
    int done_cyc = -1;
    bit done_rdy = 1'b0;

    always @(negedge clk) begin
        if (rdata_valid) begin
            rq_data.push_back(rdata);
            rq_last.push_back(rdata_last);
            rq_cyc.push_back(cyc);
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            done_rdy = cmd_ready;
        end
    end

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wd [DEPTH];

    function automatic logic [63:0] outs();
        return 64'({cmd_ready, wdata_ready, rdata_valid, rdata_last,
                    busy_o, done_o, mif.mem_valid_o, mif.mem_wr_rd_o,
                    mif.mem_addr_o, rdata, mif.mem_wr_data_o});
    endfunction

    task automatic rand_inputs();
        cmd_valid   = 1'($urandom);
        cmd_wr      = 1'($urandom);
        cmd_addr    = AW'($urandom);
        cmd_len     = LW'($urandom);
        wdata_valid = 1'($urandom);
        wdata       = DW'($urandom);
        mif.mem_ready_i = 1'($urandom);
    endtask

    task automatic send_cmd(input bit wr, input int addr, input int len);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("cmd_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = AW'(addr);
        cmd_len   = LW'(len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_len   = LW'($urandom);
    endtask

    // mode: 0 ready always, 1 ready 1,0,1,0..., 2 random ready
    task automatic burst(input bit wr, input int addr, input int len,
                         input int mode, input bit gaps);
        int h0, r0, d0, beats, n, errs, aerr, leak, drop, li;
        bit prev_stall;
        h0 = hs_addr.size();
        r0 = rq_data.size();
        d0 = done_cnt;
        send_cmd(wr, addr, len);
        beats = 0;
        n = 0;
        aerr = 0;
        leak = 0;
        drop = 0;
        prev_stall = 1'b0;
        while (beats <= len && n < 400) begin
            case (mode)
                0: mif.mem_ready_i = 1'b1;
                1: mif.mem_ready_i = (n % 2 == 0);
                default: mif.mem_ready_i = ($urandom % 3 != 0);
            endcase
            if (wr) begin
                wdata_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
                wdata = wd[beats];
            end else begin
                wdata_valid = 1'($urandom);
                wdata = DW'($urandom);
            end
            @(negedge clk);
            if (int'(mif.mem_addr_o) != (addr + beats) % DEPTH) aerr++;
            if (!wr && wdata_ready) leak++;
            if (!wr && prev_stall && !mif.mem_valid_o) drop++;
            prev_stall = mif.mem_valid_o && !mif.mem_ready_i;
            if (mif.mem_valid_o && mif.mem_ready_i) beats++;
            @(posedge clk);
            #1;
            n++;
        end
        mif.mem_ready_i = 1'($urandom);
        wdata_valid = 1'b0;
        chk("beats", 64'(beats), 64'(len + 1));
        chk("addr_track", 64'(aerr), 64'(0));
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("done_cnt", 64'(done_cnt - d0), 64'(1));
        chk("done_rdy", 64'(done_rdy), 64'(1));
        chk("busy_after", 64'(busy_o), 64'(0));
        chk("hs_cnt", 64'(hs_addr.size() - h0), 64'(len + 1));
        errs = 0;
        for (int i = 0; i <= len; i++) begin
            if (h0 + i >= hs_addr.size()) errs++;
            else if (hs_addr[h0+i] != (addr + i) % DEPTH ||
                     hs_wr[h0+i] != int'(wr)) errs++;
        end
        chk("hs_addr_seq", 64'(errs), 64'(0));
        li = h0 + len;
        if (mode == 0 && !gaps) begin
            if (li < hs_cyc.size())
                chk("back2back", 64'(hs_cyc[li] - hs_cyc[h0]), 64'(len));
            else
                chk("back2back", 64'(0), 64'(1));
        end
        if (wr) begin
            for (int i = 0; i <= len; i++)
                ref_mem[(addr + i) % DEPTH] = wd[i];
            errs = 0;
            for (int i = 0; i < DEPTH; i++)
                if (bfm_mem[i] !== ref_mem[i]) errs++;
            chk("mem_image", 64'(errs), 64'(0));
            if (li < hs_cyc.size())
                chk("wr_done_lat", 64'(done_cyc), 64'(hs_cyc[li] + 1));
            else
                chk("wr_done_lat", 64'(0), 64'(1));
        end else begin
            chk("rd_cnt", 64'(rq_data.size() - r0), 64'(len + 1));
            errs = 0;
            for (int i = 0; i <= len; i++) begin
                if (r0 + i >= rq_data.size() || h0 + i >= hs_cyc.size())
                    errs++;
                else if (rq_data[r0+i] !== ref_mem[(addr + i) % DEPTH] ||
                         rq_last[r0+i] != (i == len) ||
                         rq_cyc[r0+i] != hs_cyc[h0+i] + 1)
                    errs++;
            end
            chk("rd_beats", 64'(errs), 64'(0));
            if (r0 + len < rq_cyc.size())
                chk("rd_done_lat", 64'(done_cyc), 64'(rq_cyc[r0+len] + 1));
            else
                chk("rd_done_lat", 64'(0), 64'(1));
            chk("wdata_ignored", 64'(leak), 64'(0));
            chk("valid_hold", 64'(drop), 64'(0));
        end
    endtask

    task automatic abort_read();
        int h0, r1, d1, n;
        h0 = hs_addr.size();
        send_cmd(1'b0, 0, 7);
        mif.mem_ready_i = 1'b1;
        n = 0;
        while (hs_addr.size() - h0 < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach", 64'(hs_addr.size() - h0), 64'(2));
        rst = 1'b0;
        #1;
        chk("abort_outs", outs(), 64'(0));
        r1 = rq_data.size();
        d1 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_rdata", 64'(rq_data.size() - r1), 64'(0));
        chk("abort_no_done", 64'(done_cnt - d1), 64'(0));
        chk("abort_idle", 64'({busy_o, cmd_ready}), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            @(negedge clk);
            chk("rst_outs", outs(), 64'(0));
        end
        cmd_valid = 1'b0;
        wdata_valid = 1'b0;
        mif.mem_ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(cmd_ready), 64'(1));
        chk("post_rst_busy", 64'(busy_o), 64'(0));

        for (int i = 0; i < DEPTH; i++) wd[i] = DW'(16'h1000 + i);
        burst(1'b1, 0, 15, 0, 1'b0);
        burst(1'b0, 0, 15, 2, 1'b0);

        for (int i = 0; i < 4; i++) wd[i] = DW'(16'h00A0 + i);
        burst(1'b1, 4, 3, 0, 1'b0);
        burst(1'b0, 4, 3, 0, 1'b0);

        for (int i = 0; i < 4; i++) wd[i] = DW'(16'h00B0 + i);
        burst(1'b1, 14, 3, 0, 1'b0);
        burst(1'b0, 14, 3, 0, 1'b0);

        for (int i = 0; i < 8; i++) wd[i] = DW'(16'h00C0 + i);
        burst(1'b1, 0, 7, 1, 1'b1);
        burst(1'b0, 0, 7, 1, 1'b0);

        abort_read();
        burst(1'b0, 0, 0, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < DEPTH; i++) wd[i] = DW'($urandom);
            burst(1'($urandom), int'($urandom % DEPTH),
                  int'($urandom % DEPTH), int'($urandom % 3),
                  1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
